// File: rtl/regfile_pkg.sv
// Shared widths and types for the 32x64 ARM register file and its decoder.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regaddr_t;
endpackage

// File: rtl/decoder5to32.sv
// Hierarchical 5:32 one-hot decoder: a 2:4 stage enables four 3:8 stages.
module dec2to4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_y
);
  assign o_y = i_en ? (4'b0001 << i_sel) : 4'b0000;
endmodule

module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_sel,
  output logic [7:0] o_y
);
  assign o_y = i_en ? (8'b0000_0001 << i_sel) : 8'b0000_0000;
endmodule

module decoder5to32
  import regfile_pkg::*;
(
  input  logic                i_en,
  input  regaddr_t            i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);
  logic [3:0] w_hi;

  dec2to4 u_hi (
    .i_en  (i_en),
    .i_sel (i_addr[4:3]),
    .o_y   (w_hi)
  );

  // Each 3:8 stage only fires when its quadrant is selected, so an X on the
  // low address bits cannot leak into the other three quadrants.
  for (genvar h = 0; h < 4; h++) begin : g_lo
    dec3to8 u_lo (
      .i_en  (w_hi[h]),
      .i_sel (i_addr[2:0]),
      .o_y   (o_onehot[h*8 +: 8])
    );
  end
endmodule

// File: rtl/mux2.sv
// Generic 2:1 mux cell used to build the register-file read trees.
module mux2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file: two combinational read ports, one clocked write port,
// X31 hardwired to zero, optional write-to-read bypass.
module regfile_32x64 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '1;

  logic [NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0]   w_regs  [NUM_REGS];
  logic [DATA_W-1:0]   w_tree1 [1:2*NUM_REGS-1];
  logic [DATA_W-1:0]   w_tree2 [1:2*NUM_REGS-1];
  logic                w_unused_zero_we;
  logic                w_wr_live;
  logic                w_byp1;
  logic                w_byp2;

  decoder5to32 u_dec (
    .i_en     (RegWrite),
    .i_addr   (WriteRegister),
    .o_onehot (w_we)
  );

  // X31 has no storage; its decoder line is deliberately left unconnected.
  assign w_unused_zero_we       = w_we[NUM_REGS-1];
  assign w_regs[NUM_REGS-1]     = '0;

  for (genvar g = 0; g < NUM_REGS-1; g++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (w_we[g]) begin
        r_q <= WriteData;
      end
    end
    assign w_regs[g] = r_q;
  end

  // Heap-ordered mux tree: node n selects between 2n and 2n+1; leaves sit at
  // NUM_REGS+addr, so address bits are consumed MSB first from the root.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_leaf
    assign w_tree1[NUM_REGS+r] = w_regs[r];
    assign w_tree2[NUM_REGS+r] = w_regs[r];
  end

  for (genvar lv = 0; lv < ADDR_W; lv++) begin : g_lvl
    for (genvar k = 0; k < (1 << lv); k++) begin : g_node
      localparam int N = (1 << lv) + k;
      mux2 #(.W(DATA_W)) u_m1 (
        .i_a   (w_tree1[2*N]),
        .i_b   (w_tree1[2*N+1]),
        .i_sel (ReadRegister1[ADDR_W-1-lv]),
        .o_y   (w_tree1[N])
      );
      mux2 #(.W(DATA_W)) u_m2 (
        .i_a   (w_tree2[2*N]),
        .i_b   (w_tree2[2*N+1]),
        .i_sel (ReadRegister2[ADDR_W-1-lv]),
        .o_y   (w_tree2[N])
      );
    end
  end

  // Bypass is suppressed during reset so reads stay zero while writes are blocked.
  assign w_wr_live = BYPASS && reset_n && RegWrite && (WriteRegister != ZERO_REG);
  assign w_byp1    = w_wr_live && (ReadRegister1 == WriteRegister);
  assign w_byp2    = w_wr_live && (ReadRegister2 == WriteRegister);

  assign ReadData1 = w_byp1 ? WriteData : w_tree1[1];
  assign ReadData2 = w_byp2 ? WriteData : w_tree2[1];
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64, run side by side with BYPASS=0 and BYPASS=1.
module tb_regfile_32x64;
  localparam int W = 64;
  localparam logic [W-1:0] K_SWEEP = 64'h0101_0101_0101_0101;
  localparam logic [W-1:0] V_DEAD  = 64'hDEAD_BEEF_0123_4567;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         RegWrite = 1'b0;
  logic [4:0]   WriteRegister = '0;
  logic [W-1:0] WriteData = '0;
  logic [4:0]   ReadRegister1 = '0;
  logic [4:0]   ReadRegister2 = '0;
  logic [W-1:0] rd0_1, rd0_2, rd1_1, rd1_2;
  logic         chk_valid = 1'b0;

  logic [4*W-1:0] exp_q[$];
  string          tag_q[$];
  int             n_checks = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  regfile_32x64 #(.BYPASS(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd0_1), .ReadData2(rd0_2)
  );

  regfile_32x64 #(.BYPASS(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_1), .ReadData2(rd1_2)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per sampled cycle, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        logic [4*W-1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "/b0_rd1"}, rd0_1, e[4*W-1:3*W]);
        check({t, "/b0_rd2"}, rd0_2, e[3*W-1:2*W]);
        check({t, "/b1_rd1"}, rd1_1, e[2*W-1:W]);
        check({t, "/b1_rd2"}, rd1_2, e[W-1:0]);
      end
    end
  end

  // Driver: one cycle of stimulus; expectations hold for the reads before the next edge.
  task automatic step(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [W-1:0] e01, input logic [W-1:0] e02,
                      input logic [W-1:0] e11, input logic [W-1:0] e12,
                      input string tag);
    @(posedge clk);
    #1;
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = ra1;
    ReadRegister2 = ra2;
    exp_q.push_back({e01, e02, e11, e12});
    tag_q.push_back(tag);
    chk_valid = 1'b1;
  endtask

  function automatic logic [W-1:0] prior(input int i);
    case (i)
      5:       return V_DEAD;
      6:       return 64'h1;
      10:      return 64'hB;
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    step(0, 0, 0, 0, 31, 0, 0, 0, 0, "reset_state");
    step(1, 5, V_DEAD, 5, 6, 0, 0, V_DEAD, 0, "wr_x5");
    step(1, 6, 64'h1, 5, 6, V_DEAD, 0, V_DEAD, 64'h1, "wr_x6");
    step(0, 0, 0, 5, 6, V_DEAD, 64'h1, V_DEAD, 64'h1, "rd_x5_x6");
    step(0, 0, 0, 7, 4, 0, 0, 0, 0, "others_zero");

    step(1, 31, '1, 31, 31, 0, 0, 0, 0, "xzr_pre");
    step(0, 0, 0, 31, 5, 0, V_DEAD, 0, V_DEAD, "xzr_post");

    step(1, 10, 64'hA, 10, 10, 0, 0, 64'hA, 64'hA, "x10_wr_a");
    step(1, 10, 64'hB, 10, 9, 64'hA, 0, 64'hB, 0, "x10_rdw");
    step(0, 0, 0, 10, 10, 64'hB, 64'hB, 64'hB, 64'hB, "x10_after");

    step(0, 3, 64'h55, 3, 3, 0, 0, 0, 0, "we_gate");
    step(0, 0, 0, 3, 10, 0, 64'hB, 0, 64'hB, "we_gate_after");

    for (int i = 0; i < 31; i++) begin
      logic [W-1:0] v;
      v = 64'(i) * K_SWEEP;
      step(1, 5'(i), v, 5'(i), 5'd31, prior(i), 0, v, 0, $sformatf("sweep_wr%0d", i));
    end
    for (int i = 0; i < 31; i++) begin
      logic [W-1:0] va, vb;
      va = 64'(i) * K_SWEEP;
      vb = 64'(30 - i) * K_SWEEP;
      step(0, 0, 0, 5'(i), 5'(30 - i), va, vb, va, vb, $sformatf("sweep_rd%0d", i));
    end
    step(0, 0, 0, 31, 31, 0, 0, 0, 0, "sweep_x31");

    // Reset falls mid-cycle during a write to X7; checked before the next edge.
    fork
      begin
        @(posedge clk);
        #3 reset_n = 1'b0;
      end
    join_none
    step(1, 7, 64'h77, 7, 30, 0, 0, 0, 0, "reset_async");
    for (int i = 0; i < 32; i++) begin
      step(1, 5'(i), '1, 5'(i), 5'(31 - i), 0, 0, 0, 0, $sformatf("reset_hold%0d", i));
    end
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    RegWrite  = 1'b0;
    reset_n   = 1'b1;
    step(0, 0, 0, 7, 5, 0, 0, 0, 0, "post_reset");
    step(1, 7, 64'h77, 7, 30, 0, 0, 64'h77, 0, "first_write");
    step(0, 0, 0, 7, 7, 64'h77, 64'h77, 64'h77, 64'h77, "first_write_after");

    @(posedge clk);
    #1 chk_valid = 1'b0;
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
